sram_mem_ctrl: RTL and testbench

//  Downstream of the MEM stage: services its data-memory requests against an external 16-bit asynchronous SRAM.

---
 rtl/sram_mem_ctrl.sv | 112 +++++++++++
 tb/tb_sram_mem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// Data-memory controller that moves 32-bit words to/from an external 16-bit
// asynchronous SRAM as two half-word phases, stalling the pipeline via ready.
module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'd1024,
  parameter int          SRAM_AW    = 18,
  parameter int          ACC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int IW = SRAM_AW - 1;
  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rbuf;
  logic [IW-1:0] idx_next;

  // Word index relative to the SRAM window; out-of-range addresses wrap silently.
  assign idx_next = IW'((address - BASE_ADDR) >> 2);

  assign ready = (state == DONE) || ((state == IDLE) && !wr_en && !rd_en);

  // SRAM pins are registered, so each phase's address/data/strobe is loaded on
  // the edge that enters the phase and held stable for all of its cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            op_wr       <= wr_en;
            idx_q       <= idx_next;
            wdata_q     <= write_data;
            cnt         <= '0;
            state       <= LOW;
            sram_addr   <= {idx_next, 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            state       <= HIGH;
            sram_addr   <= {idx_q, 1'b1};
            sram_dq_out <= wdata_q[31:16];
            if (!op_wr) begin
              rbuf[15:0] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!op_wr) begin
              rbuf[31:16] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (!op_wr) begin
            read_data <= rbuf;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: an async SRAM model on the pins plus a
// word-level reference memory that predicts ready/read_data/strobes each cycle.
module tb_sram_mem_ctrl;

  localparam int N = 2;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks;
  int errors;

  logic        cmp_en;
  logic        exp_ready;
  logic        exp_we_n;
  logic        exp_oe;
  logic        addr_chk;
  logic [17:0] exp_addr;
  logic        dq_chk;
  logic [15:0] exp_dq;
  logic [31:0] exp_rdata;
  logic [31:0] exp_rdata_next;

  logic [15:0] sram_mem [0:262143];
  logic [31:0] model_mem [int];

  sram_mem_ctrl #(
    .BASE_ADDR  (32'd1024),
    .SRAM_AW    (18),
    .ACC_CYCLES (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write committed while we_n is low.
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("ready", {31'b0, ready}, {31'b0, exp_ready});
      checkOutput("read_data", read_data, exp_rdata);
      checkOutput("we_n", {31'b0, sram_we_n}, {31'b0, exp_we_n});
      checkOutput("oe", {31'b0, sram_dq_oe}, {31'b0, exp_oe});
      if (addr_chk) checkOutput("sram_addr", {14'b0, sram_addr}, {14'b0, exp_addr});
      if (dq_chk) checkOutput("sram_dq_out", {16'b0, sram_dq_out}, {16'b0, exp_dq});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    exp_rdata = exp_rdata_next;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      exp_ready = 1'b1;
      exp_we_n  = 1'b1;
      exp_oe    = 1'b0;
      addr_chk  = 1'b0;
      dq_chk    = 1'b0;
    end
  endtask

  function automatic logic [16:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - 32'd1024) >> 2;
    return off[16:0];
  endfunction

  // One full transaction, cycle 0 = request seen in IDLE, DONE at 2N+1.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic scramble);
    logic [16:0] idx;
    idx = word_idx(addr);
    for (int k = 0; k <= 2 * N + 1; k++) begin
      cycle();
      if (k == 0) begin
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
      end else if (scramble) begin
        address    = $urandom;
        write_data = $urandom;
      end
      exp_ready = (k == 2 * N + 1);
      addr_chk  = (k >= 1) && (k <= 2 * N);
      exp_we_n  = !(wr && addr_chk);
      exp_oe    = wr && addr_chk;
      exp_addr  = {idx, (k > N)};
      dq_chk    = wr && addr_chk;
      exp_dq    = (k > N) ? data[31:16] : data[15:0];
    end
    if (wr) model_mem[int'(idx)] = data;
    else exp_rdata_next = model_mem.exists(int'(idx)) ? model_mem[int'(idx)] : 32'h0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    cmp_en = 1'b0; exp_rdata = '0; exp_rdata_next = '0;
    exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe = 1'b0;
    addr_chk = 1'b0; exp_addr = '0; dq_chk = 1'b0; exp_dq = '0;

    // Reset held two clocks; the pins must show their reset values.
    cycle();
    cmp_en = 1'b1; addr_chk = 1'b1; dq_chk = 1'b1;
    cycle();
    rst = 1'b1;
    idle(1);

    applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    checkOutput("sram_hw0", {16'b0, sram_mem[0]}, 32'h0000BEEF);
    checkOutput("sram_hw1", {16'b0, sram_mem[1]}, 32'h0000DEAD);
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    idle(1);
    checkOutput("load_1024", read_data, 32'hDEADBEEF);

    // Back-to-back accesses with inputs scrambled after the latch cycle.
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h11112222, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'h33334444, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'd1029, 32'h0, 1'b0);
    idle(2);
    checkOutput("load_1029", read_data, 32'h11112222);

    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
    idle(1);
    checkOutput("both_keeps_rdata", read_data, 32'h11112222);
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
    idle(1);

    // Address below the window wraps to the top of the SRAM.
    applyStimulus(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 1'b0);
    checkOutput("wrap_low_hw", {16'b0, sram_mem[18'h3FFFE]}, 32'h00005A5A);
    applyStimulus(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
    idle(1);
    checkOutput("wrap_load", read_data, 32'hA5A55A5A);

    // Reset in cycle 2 of a store aborts it.
    cycle();
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = 32'h55556666;
    exp_ready = 1'b0; exp_we_n = 1'b1; exp_oe = 1'b0; addr_chk = 1'b0; dq_chk = 1'b0;
    cycle();
    exp_we_n = 1'b0; exp_oe = 1'b1; addr_chk = 1'b1; dq_chk = 1'b1;
    exp_addr = {word_idx(32'd1036), 1'b0}; exp_dq = 16'h6666;
    cycle();
    rst = 1'b0;
    exp_rdata_next = 32'h0;
    cycle();
    rst = 1'b1; wr_en = 1'b0;
    exp_ready = 1'b1; exp_we_n = 1'b1; exp_oe = 1'b0; addr_chk = 1'b0; dq_chk = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    idle(2);
    checkOutput("load_after_reset", read_data, 32'h11112222);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
